elevator_call_panel: RTL
========================

Name: elevator_call_panel

Overview:
Request side of the elevator interface. Turns raw hall and cabin button presses into the latched `button_up` / `button_down` / `button_in` request vectors that the elevator controller consumes. It watches the controller's `position` / `open` / `direction` outputs and clears each request when the car serves it. It also generates an arrival chime pulse, a stall watchdog and a sticky protocol-fault flag.

Parameters:
STALL_CYCLES, 16, cycles with requests pending and no change in {position, open} before `stall` asserts; legal range 2..255.
CNT_W, 8, width of the stall counter; must satisfy 2^CNT_W > STALL_CYCLES.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
press_up  in  3  raw hall-up buttons, level; [0] 1st floor, [1] 2nd, [2] 3rd.
press_down  in  3  raw hall-down buttons, level; [0] 2nd floor, [1] 3rd, [2] 4th.
press_in  in  4  raw cabin buttons, level; [k] floor k+1.
position  in  3  controller position; even code = at floor (code>>1), odd code = between floors.
open  in  1  controller door state; 1 = open.
direction  in  2  controller direction; 00 stop, 01 up, 10 down.
button_up  out  3  latched hall-up requests; drives the controller and the hall lamps.
button_down  out  3  latched hall-down requests.
button_in  out  4  latched cabin requests.
chime  out  1  one-cycle pulse on door opening at a floor.
stall  out  1  watchdog flag.
fault  out  1  sticky protocol-violation flag.

Behaviour:
- **Reset:** all outputs 0, press-history registers 0, previous {position, open} register 0, stall counter 0.
- **Register clocking:** all registers update on rising `clk`. The controller samples on falling `clk`, so the request outputs are stable half a cycle before it samples them.

Set rule, per request bit:
- Set on a rising edge of the corresponding press bit: press=1 and the previous-cycle press=0.
- The bit is visible one cycle after the sampling edge.
- A held press does not re-set a bit after it has been cleared.

Service condition: `open`=1 and `position[0]`=0, with floor f = `position[2:1]`.
- **Cabin:** clear `button_in[f]`.
- **Hall up:** clear `button_up[f]` when f≤2 and `direction` is 00 or 01.
- **Hall down:** clear `button_down[f-1]` when f≥1 and `direction` is 00 or 10.
- Clears take effect at the same edge that samples the service condition.
- **Set and clear on the same bit in the same cycle:** clear wins, because the request is being served.
- Bits with no service condition this cycle hold their value.

Chime:
- `chime`=1 for exactly one cycle when `open`=1 and `position[0]`=0 now, and the previous-cycle `open`=0.

Stall watchdog:
- `pending` = OR of all request outputs.
- Each cycle: if `pending`=0, or {position, open} differs from the previous cycle, the counter goes to 0.
- Otherwise the counter increments, saturating at STALL_CYCLES.
- `stall` = (counter == STALL_CYCLES), registered.
- `stall` drops the cycle after motion resumes or all requests clear.

Fault (sticky until reset), set by any of:
- `position` = 111;
- `direction` = 11;
- `open`=1 while `position[0]`=1;
- `position` changing by more than 1 code between consecutive cycles.

Fault cases and clearing:
- **Invalid `direction` (11):** suppresses hall clears that cycle; cabin clears still apply.
- **Invalid `position` (111):** suppresses all clears.
- **Reset mid-operation:** all requests are dropped immediately (asynchronous reset). Presses held through reset release are not latched until released and pressed again.

Decomposition:
- **Shared package `elevator_pkg`:**
  - DIR_STOP=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10;
  - FLOORS=4;
  - POS_TOP=3'b110;
  - function `at_floor(pos)`.
- **Sub-module `call_latch`:** one request bit containing the press-edge detector and set/clear register with clear priority; instantiated 10 times.
- **Top level:** service decode, chime, watchdog and fault logic.

Test Plan:
- **Cabin request and service:** pulse `press_in`=0100 for 1 cycle with pos=000, open=0 -> `button_in`=0100 next cycle. Then drive pos=100, open=1, dir=00 -> `button_in`=0000 next cycle, and `chime`=1 for one cycle.
- **Direction-qualified hall clear:** set `button_up[1]` and `button_down[0]`, then drive pos=010, open=1, dir=01 -> `button_up`=000 and `button_down`=001 retained. Then dir=10 -> `button_down`=000.
- **Clear priority and held press:** hold `press_down[2]`=1 while pos=110, open=1, dir=10 -> `button_down[2]` stays 0. Keep the press held after open=0 -> stays 0. Release and press again -> bit becomes 1.
- **Watchdog:** STALL_CYCLES=16, one request pending, pos/open frozen -> `stall`=1 after 16 frozen cycles. Change pos to 001 -> `stall`=0 the following cycle.
- **Fault:** drive pos=011 with open=1 -> `fault`=1 and remains 1 after legal inputs resume. Assert reset_n=0 mid-operation -> all outputs 0 immediately.
- **Top floor boundary:** pos=110, open=1, dir=00 with `button_in[3]` and `button_down[2]` set -> both clear; `button_up` is unaffected.

Source files
------------

// File: rtl/elevator_call_panel_pkg.sv
// Shared constants and helpers for the elevator request side.
package elevator_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  localparam int FLOORS = 4;

  localparam logic [2:0] POS_TOP = 3'b110;

  // Even position codes mean the car is level with a floor.
  function automatic logic at_floor(input logic [2:0] pos);
    return !pos[0];
  endfunction

endpackage

// File: rtl/elevator_call_panel_call_latch.sv
// One request bit: press rising-edge detector feeding a set/clear latch.
module call_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic i_press,
  input  logic i_setEn,
  input  logic i_clear,
  output logic o_request
);

  logic r_pressPrev;
  logic r_request;

  // Clear beats set so a press made while the car is serving that call is absorbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pressPrev <= 1'b0;
      r_request   <= 1'b0;
    end else begin
      r_pressPrev <= i_press;
      if (i_clear) begin
        r_request <= 1'b0;
      end else if (i_setEn && i_press && !r_pressPrev) begin
        r_request <= 1'b1;
      end
    end
  end

  assign o_request = r_request;

endmodule

// File: rtl/elevator_call_panel.sv
// Latches hall/cabin calls, clears them on service, and flags chime, stall and protocol faults.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int STALL_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] press_up,
  input  logic [2:0] press_down,
  input  logic [3:0] press_in,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [3:0] button_in,
  output logic       chime,
  output logic       stall,
  output logic       fault
);

  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  logic             r_started;
  logic [2:0]       r_prevPos;
  logic             r_prevOpen;
  logic             r_chime;
  logic             r_stall;
  logic             r_fault;
  logic [CNT_W-1:0] r_stallCnt;

  logic             w_service;
  logic [1:0]       w_floor;
  logic             w_upDirOk;
  logic             w_downDirOk;
  logic [2:0]       w_clearUp;
  logic [2:0]       w_clearDown;
  logic [3:0]       w_clearIn;
  logic             w_pending;
  logic             w_moved;
  logic [CNT_W-1:0] w_stallCntNext;
  logic [2:0]       w_posDelta;
  logic             w_jump;
  logic             w_faultNow;

  assign w_floor     = position[2:1];
  assign w_service   = open && at_floor(position) && (position <= POS_TOP);
  assign w_upDirOk   = (direction == DIR_STOP) || (direction == DIR_UP);
  assign w_downDirOk = (direction == DIR_STOP) || (direction == DIR_DOWN);

  // Hall-down index k belongs to floor k+1, so it is cleared from one floor higher.
  always_comb begin
    w_clearUp   = '0;
    w_clearDown = '0;
    w_clearIn   = '0;
    for (int k = 0; k < FLOORS; k++) begin
      w_clearIn[k] = w_service && (w_floor == 2'(k));
    end
    for (int k = 0; k < 3; k++) begin
      w_clearUp[k]   = w_service && w_upDirOk && (w_floor == 2'(k));
      w_clearDown[k] = w_service && w_downDirOk && (w_floor == 2'(k + 1));
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gen_hall
    call_latch u_up (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_press  (press_up[g]),
      .i_setEn  (r_started),
      .i_clear  (w_clearUp[g]),
      .o_request(button_up[g])
    );
    call_latch u_down (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_press  (press_down[g]),
      .i_setEn  (r_started),
      .i_clear  (w_clearDown[g]),
      .o_request(button_down[g])
    );
  end

  for (genvar g = 0; g < FLOORS; g++) begin : gen_cabin
    call_latch u_in (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_press  (press_in[g]),
      .i_setEn  (r_started),
      .i_clear  (w_clearIn[g]),
      .o_request(button_in[g])
    );
  end

  always_comb begin
    w_pending = |{button_up, button_down, button_in};
    w_moved   = ({position, open} != {r_prevPos, r_prevOpen});
    w_stallCntNext = r_stallCnt;
    if (!w_pending || w_moved) begin
      w_stallCntNext = '0;
    end else if (r_stallCnt != STALL_MAX) begin
      w_stallCntNext = r_stallCnt + 1'b1;
    end
  end

  // The first cycle after reset has no meaningful previous position to compare against.
  assign w_posDelta = (position >= r_prevPos) ? (position - r_prevPos) : (r_prevPos - position);
  assign w_jump     = r_started && (w_posDelta > 3'd1);
  assign w_faultNow = (position > POS_TOP) || (direction == DIR_BAD) ||
                      (open && position[0]) || w_jump;

  // r_started also masks the first press sample so a button held through reset is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_started  <= 1'b0;
      r_prevPos  <= 3'b000;
      r_prevOpen <= 1'b0;
      r_chime    <= 1'b0;
      r_stall    <= 1'b0;
      r_fault    <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_started  <= 1'b1;
      r_prevPos  <= position;
      r_prevOpen <= open;
      r_chime    <= open && at_floor(position) && !r_prevOpen;
      r_stallCnt <= w_stallCntNext;
      r_stall    <= (w_stallCntNext == STALL_MAX);
      r_fault    <= r_fault || w_faultNow;
    end
  end

  assign chime = r_chime;
  assign stall = r_stall;
  assign fault = r_fault;

endmodule
